// File: rtl/mem_port_arbiter_if.sv
// Bus between the three requesters and the shared-port arbiter.
//
// Handshake: a requester raises its req bit and holds it until it sees its
// gnt bit; the grant then stays put (req changes are ignored) until the port
// pulses done in a grant cycle. A requester that is finished must drop req in
// that same done cycle, otherwise it competes again (at lowest priority).
// done outside a grant carries no meaning and is ignored.
// state is a debug copy of the arbiter FSM (0 = IDLE, 1 = GRANT).
interface mem_port_arbiter_if;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout_err;
    logic       state;

    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout_err,
        input  state
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output timeout_err,
        output state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory/datapath port among three requesters
// (fetch / load-store / aux). Drives the select of the 3-input port mux:
// 00/01/10 pick input 1/2/3, 11 makes the mux output zero (idle).
// Grants are held until the port reports done.
//
// Optional feature: define ARB_TIMEOUT_EN to force-release a grant that has
// been held for TIMEOUT_CYCLES cycles without done; timeout_err pulses for one
// cycle afterwards. Without the macro there is no counter and timeout_err is 0.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [2:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       win_valid;
    logic [1:0] win_idx;
    logic [2:0] win_onehot;
    logic       timeout_hit;
    logic       release_now;
    logic       take;

    // A nonsensical timeout setting leaves nothing to elaborate here; the
    // block only keeps the parameter referenced in every build.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    end

    // Round-robin search: ptr+1, ptr+2, then ptr itself (mod 3); first set req wins.
    always_comb begin
        cand1     = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        cand2     = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        win_valid = 1'b1;
        win_idx   = ptr_q;
        if (bus.req[cand1]) begin
            win_idx = cand1;
        end else if (bus.req[cand2]) begin
            win_idx = cand2;
        end else if (bus.req[ptr_q]) begin
            win_idx = ptr_q;
        end else begin
            win_valid = 1'b0;
        end
    end

    // One-hot decode of the winning index.
    always_comb begin
        win_onehot = 3'b000;
        case (win_idx)
            2'd0:    win_onehot = 3'b001;
            2'd1:    win_onehot = 3'b010;
            2'd2:    win_onehot = 3'b100;
            default: win_onehot = 3'b000;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             terr_q;

    // Forced release only when the limit is reached and done is not there;
    // done in the same cycle takes precedence and reports no error.
    always_comb begin
        timeout_hit = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !bus.done;
    end

    // Grant-cycle counter: 1 on the first grant cycle, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (take) begin
            cnt_q <= win_valid ? CNT_W'(1) : '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Error pulse in the cycle following a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= timeout_hit;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    always_comb begin
        timeout_hit = 1'b0;
    end

    assign bus.timeout_err = 1'b0;
`endif

    // A grant ends on done or on a forced release; IDLE always arbitrates.
    always_comb begin
        release_now = (state_q == GRANT) && (bus.done || timeout_hit);
        take        = (state_q == IDLE) || release_now;
    end

    // Arbiter FSM: all outputs registered; a release with pending requests
    // hands straight over to the next winner without an idle bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b11;
            busy_q  <= 1'b0;
        end else if (take) begin
            if (win_valid) begin
                state_q <= GRANT;
                ptr_q   <= win_idx;
                gnt_q   <= win_onehot;
                sel_q   <= win_idx;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                gnt_q   <= 3'b000;
                sel_q   <= 2'b11;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.state = state_q;

endmodule
